// File: rtl/pu_sequencer.sv
// pu_sequencer: gathers LANES x/w beats, strobes the process unit, and
// captures its result with a ready/valid handshake toward the sink.
//
// Ports:
//   clock, reset_n           clock and async active-low reset
//   in_x, in_w, in_valid     operand/weight beat from the source
//   in_ready                 high while the sequencer accepts beats
//   x, w                     lane vectors to the process unit, lane i at [i*WIDTH +: WIDTH]
//   load_mult, load_sum      process-unit register load strobes
//   pu_out, pu_s             process-unit result and its zero flag
//   res_data, res_zero       captured result and zero flag
//   res_valid, res_ready     result handshake toward the sink
//   err                      sticky: pu_s disagreed with (pu_out == 0)
module pu_sequencer #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       in_x,
    input  logic [WIDTH-1:0]       in_w,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LANES*WIDTH-1:0] x,
    output logic [LANES*WIDTH-1:0] w,
    output logic                   load_mult,
    output logic                   load_sum,
    input  logic [WIDTH-1:0]       pu_out,
    input  logic                   pu_s,
    output logic [WIDTH-1:0]       res_data,
    output logic                   res_zero,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   err
);

    typedef enum logic [2:0] {
        FILL,
        MULT,
        SUM,
        CAP,
        HOLD
    } state_t;

    localparam logic [1:0] LAST = 2'(LANES - 1);

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [LANES*WIDTH-1:0] x_q, x_d;
    logic [LANES*WIDTH-1:0] w_q, w_d;
    logic [WIDTH-1:0]       res_data_q, res_data_d;
    logic                   res_zero_q, res_zero_d;
    logic                   err_q, err_d;
    logic                   in_ready_q, in_ready_d;
    logic                   load_mult_q, load_mult_d;
    logic                   load_sum_q, load_sum_d;
    logic                   res_valid_q, res_valid_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        w_d        = w_q;
        res_data_d = res_data_q;
        res_zero_d = res_zero_q;
        err_d      = err_q;
        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (cnt_q == 2'(i)) begin
                            x_d[i*WIDTH +: WIDTH] = in_x;
                            w_d[i*WIDTH +: WIDTH] = in_w;
                        end
                    end
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST) begin
                        cnt_d   = 2'd0;
                        state_d = MULT;
                    end
                end
            end
            MULT: state_d = SUM;
            SUM:  state_d = CAP;
            CAP: begin
                res_data_d = pu_out;
                res_zero_d = pu_s;
                // Flag is trusted only if it agrees with an unsigned zero test.
                if (pu_s != (pu_out == '0)) begin
                    err_d = 1'b1;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Strobes decode the next state so they are flops aligned with it.
    always_comb begin
        in_ready_d  = (state_d == FILL);
        load_mult_d = (state_d == MULT);
        load_sum_d  = (state_d == SUM);
        res_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            cnt_q       <= 2'd0;
            x_q         <= '0;
            w_q         <= '0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            load_mult_q <= 1'b0;
            load_sum_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            w_q         <= w_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            load_mult_q <= load_mult_d;
            load_sum_q  <= load_sum_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign x         = x_q;
    assign w         = w_q;
    assign load_mult = load_mult_q;
    assign load_sum  = load_sum_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pu_sequencer.sv
// tb_pu_sequencer: scoreboard bench for pu_sequencer with a small
// behavioural process unit that can be overridden to inject results.
module tb_pu_sequencer;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [31:0]  in_x, in_w;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] x, w;
    logic         load_mult, load_sum;
    logic [31:0]  pu_out;
    logic         pu_s;
    logic [31:0]  res_data;
    logic         res_zero, res_valid;
    logic         res_ready;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_mult = 0;

    typedef struct {
        logic [31:0] d;
        logic        z;
    } exp_t;
    exp_t sb[$];

    logic [31:0] prod[4];
    logic [31:0] acc;
    logic        ovr = 1'b0;
    logic [31:0] ovr_d = 32'd0;
    logic        ovr_s = 1'b0;

    pu_sequencer #(.WIDTH(32), .LANES(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_x(in_x), .in_w(in_w),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .w(w),
        .load_mult(load_mult), .load_sum(load_sum),
        .pu_out(pu_out), .pu_s(pu_s),
        .res_data(res_data), .res_zero(res_zero),
        .res_valid(res_valid), .res_ready(res_ready),
        .err(err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (load_mult) begin
            for (int i = 0; i < 4; i++) prod[i] <= x[i*32 +: 32] * w[i*32 +: 32];
            n_mult <= n_mult + 1;
        end
        if (load_sum) acc <= prod[0] + prod[1] + prod[2] + prod[3];
    end

    assign pu_out = ovr ? ovr_d : acc;
    assign pu_s   = ovr ? ovr_s : (acc == 32'd0);

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dot(input logic [31:0] a[4],
                                        input logic [31:0] b[4]);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < 4; i++) s = s + a[i] * b[i];
        return s;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [31:0] xv, input logic [31:0] wv);
        int t = 0;
        in_valid = 1'b1;
        in_x = xv;
        in_w = wv;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) check("beat_wait", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] xa[4], input logic [31:0] wa[4]);
        exp_t e;
        if (ovr) begin
            e.d = ovr_d;
            e.z = ovr_s;
        end else begin
            e.d = dot(xa, wa);
            e.z = (e.d == 32'd0);
        end
        sb.push_back(e);
    endtask

    task automatic check_result();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("res_data", res_data, e.d);
            check("res_zero", res_zero, e.z);
        end
    endtask

    task automatic wait_result();
        int t = 0;
        while (!res_valid && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) check("res_wait", 0, 1);
        check_result();
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("rdy_after_hs", in_ready, 1);
        check("rv_after_hs", res_valid, 0);
    endtask

    task automatic run_vec(input logic [31:0] xa[4], input logic [31:0] wa[4],
                           input bit hold);
        logic [127:0] xv, wv;
        push_exp(xa, wa);
        for (int k = 0; k < 4; k++) begin
            xv[k*32 +: 32] = xa[k];
            wv[k*32 +: 32] = wa[k];
            beat(xa[k], wa[k]);
        end
        check("x_vec", x, xv);
        check("w_vec", w, wv);
        check("lm_T", load_mult, 1);
        check("ls_T", load_sum, 0);
        check("rdy_T", in_ready, 0);
        tick();
        check("lm_T1", load_mult, 0);
        check("ls_T1", load_sum, 1);
        tick();
        check("lm_T2", load_mult, 0);
        check("ls_T2", load_sum, 0);
        check("rv_T2", res_valid, 0);
        tick();
        check("rv_T3", res_valid, 1);
        check_result();
        if (!hold) take_result();
    endtask

    initial begin
        logic [31:0] xa[4];
        logic [31:0] wa[4];
        logic [31:0] rd;
        logic [127:0] xs;
        int m0;

        reset_n   = 1'b0;
        in_x      = 32'd0;
        in_w      = 32'd0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        #3;
        check("rst_x", x, 0);
        check("rst_rv", res_valid, 0);
        check("rst_err", err, 0);
        #20;
        reset_n = 1'b1;
        tick();
        check("rdy_post_rst", in_ready, 1);

        // Back-to-back dot product of 70.
        xa = '{32'd1, 32'd2, 32'd3, 32'd4};
        wa = '{32'd5, 32'd6, 32'd7, 32'd8};
        m0 = n_mult;
        run_vec(xa, wa, 1'b0);
        check("mult_once_a", n_mult - m0, 1);

        // Zero vector, with res_ready held high throughout.
        res_ready = 1'b1;
        xa = '{32'd0, 32'd0, 32'd0, 32'd0};
        wa = '{32'd9, 32'd8, 32'd7, 32'd6};
        run_vec(xa, wa, 1'b0);
        check("err_zero", err, 0);

        // in_valid alternating across 8 cycles.
        xa = '{32'd10, 32'd11, 32'd12, 32'd13};
        wa = '{32'd1, 32'd2, 32'd3, 32'd4};
        push_exp(xa, wa);
        m0 = n_mult;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_x = in_valid ? xa[i/2] : 32'hBAD0_0000;
            in_w = in_valid ? wa[i/2] : 32'hBAD0_0001;
            tick();
        end
        in_valid = 1'b0;
        check("tog_x", x, {32'd13, 32'd12, 32'd11, 32'd10});
        check("tog_w", w, {32'd4, 32'd3, 32'd2, 32'd1});
        wait_result();
        take_result();
        check("tog_mult_once", n_mult - m0, 1);

        // Sink stalls for 10 cycles while the source keeps pushing.
        xa = '{32'd100, 32'd200, 32'd300, 32'd400};
        wa = '{32'd2, 32'd3, 32'd4, 32'd5};
        run_vec(xa, wa, 1'b1);
        rd = res_data;
        xs = x;
        in_valid = 1'b1;
        in_x = 32'hDEAD_BEEF;
        in_w = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_rv", res_valid, 1);
            check("hold_rd", res_data, rd);
            check("hold_rdy", in_ready, 0);
        end
        check("hold_x", x, xs);
        res_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        res_ready = 1'b0;
        check("hold_rel_rdy", in_ready, 1);
        check("hold_rel_rv", res_valid, 0);
        check("hold_rel_x", x, xs);

        // Reset mid-fill discards the partial vector.
        beat(32'd7, 32'd7);
        beat(32'd8, 32'd8);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_x", x, 0);
        check("arst_w", w, 0);
        check("arst_rd", res_data, 0);
        check("arst_lm", load_mult, 0);
        check("arst_rv", res_valid, 0);
        #2;
        reset_n = 1'b1;
        tick();
        check("arst_rdy", in_ready, 1);
        m0 = n_mult;
        xa = '{32'd3, 32'd1, 32'd4, 32'd1};
        wa = '{32'd5, 32'd9, 32'd2, 32'd6};
        run_vec(xa, wa, 1'b0);
        check("arst_mult_once", n_mult - m0, 1);

        // Inconsistent flag from the process unit sets a sticky error.
        check("err_before", err, 0);
        ovr = 1'b1;
        ovr_d = 32'd5;
        ovr_s = 1'b1;
        run_vec(xa, wa, 1'b0);
        check("err_set", err, 1);
        ovr = 1'b0;
        xa = '{32'd1, 32'd1, 32'd1, 32'd1};
        wa = '{32'd2, 32'd2, 32'd2, 32'd2};
        run_vec(xa, wa, 1'b0);
        run_vec(wa, xa, 1'b0);
        check("err_sticky", err, 1);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
